// File: rtl/wb_master_bridge_if.sv
// Wishbone classic bus between the CPU bridge (master) and a bus slave.
// Signal names are seen from the master side.
interface wb_master_bridge_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0]   o_wishbone_addr;
    logic [DW-1:0]   o_wishbone_data;
    logic            o_wishbone_we;
    logic [DW/8-1:0] o_wishbone_sel;
    logic            o_wishbone_stb;
    logic            o_wishbone_cyc;
    logic [DW-1:0]   i_wishbone_data;
    logic            i_wishbone_ack;
    logic            i_wishbone_err;

    modport master (
        output o_wishbone_addr, o_wishbone_data, o_wishbone_we,
               o_wishbone_sel, o_wishbone_stb, o_wishbone_cyc,
        input  i_wishbone_data, i_wishbone_ack, i_wishbone_err
    );

    modport slave (
        input  o_wishbone_addr, o_wishbone_data, o_wishbone_we,
               o_wishbone_sel, o_wishbone_stb, o_wishbone_cyc,
        output i_wishbone_data, i_wishbone_ack, i_wishbone_err
    );
endinterface

// File: rtl/wb_master_bridge.sv
// Single-access Wishbone master for a CPU load/store unit: stalls the pipeline
// while a bus cycle is open and holds results through pipeline stalls.
module wb_master_bridge #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int N_STALL = 6,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_STALL-1:0] i_stall,
    input  logic               i_flush,
    input  logic               i_cpu_ce,
    input  logic [DW-1:0]      i_cpu_data,
    input  logic [AW-1:0]      i_cpu_addr,
    input  logic               i_cpu_we,
    input  logic [DW/8-1:0]    i_cpu_sel,
    output logic [DW-1:0]      o_cpu_data,
    output logic               o_bus_err,
    output logic               o_stallreq,
    wb_master_bridge_if.master wb
);

    if (DW != 32 && DW != 64) begin : g_bad_dw
        $error("wb_master_bridge: DW must be 32 or 64");
    end

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        WAIT = 2'b10
    } state_t;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic            we;
        logic [DW/8-1:0] sel;
    } req_t;

    state_t        state;
    logic [CW-1:0] cnt;
    req_t          req_q;
    logic          cyc_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;

    logic start;
    logic busy_live;
    logic tmo_hit;
    logic term;
    logic term_err;
    logic ack_ok;

    // Flush wins over every termination source in the same BUSY cycle.
    always_comb begin
        start     = (state == IDLE) && i_cpu_ce && !i_flush;
        busy_live = (state == BUSY) && !i_flush;
        tmo_hit   = (TIMEOUT != 0) && (cnt == CNT_LAST)
                    && !wb.i_wishbone_ack && !wb.i_wishbone_err;
        term      = busy_live && (wb.i_wishbone_ack || wb.i_wishbone_err || tmo_hit);
        term_err  = busy_live && (wb.i_wishbone_err || tmo_hit);
        ack_ok    = busy_live && wb.i_wishbone_ack && !wb.i_wishbone_err;
    end

    always_comb begin
        o_stallreq = start || (busy_live && !term);
        o_bus_err  = term_err || ((state == WAIT) && err_q);
        o_cpu_data = '0;
        if (ack_ok && !req_q.we) begin
            o_cpu_data = wb.i_wishbone_data;
        end else if (state == WAIT) begin
            o_cpu_data = rdata_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            req_q   <= '0;
            cyc_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= BUSY;
                        cnt     <= '0;
                        req_q   <= '{addr: i_cpu_addr, data: i_cpu_data,
                                     we: i_cpu_we, sel: i_cpu_sel};
                        cyc_q   <= 1'b1;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (i_flush) begin
                        state <= IDLE;
                        req_q <= '0;
                        cyc_q <= 1'b0;
                    end else if (term) begin
                        state   <= (|i_stall) ? WAIT : IDLE;
                        req_q   <= '0;
                        cyc_q   <= 1'b0;
                        rdata_q <= (ack_ok && !req_q.we) ? wb.i_wishbone_data : '0;
                        err_q   <= term_err;
                    end
                end
                WAIT: begin
                    if (i_stall == '0) begin
                        state   <= IDLE;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    req_q   <= '0;
                    cyc_q   <= 1'b0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wb.o_wishbone_addr = req_q.addr;
    assign wb.o_wishbone_data = req_q.data;
    assign wb.o_wishbone_we   = req_q.we;
    assign wb.o_wishbone_sel  = req_q.sel;
    assign wb.o_wishbone_stb  = cyc_q;
    assign wb.o_wishbone_cyc  = cyc_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge (TIMEOUT=4): inputs change 1ns after the
// rising edge, outputs are compared on the falling edge.
module tb_wb_master_bridge;

    logic        i_clk;
    logic        i_rst;
    logic [5:0]  i_stall;
    logic        i_flush;
    logic        i_cpu_ce;
    logic [31:0] i_cpu_data;
    logic [31:0] i_cpu_addr;
    logic        i_cpu_we;
    logic [3:0]  i_cpu_sel;
    logic [31:0] o_cpu_data;
    logic        o_bus_err;
    logic        o_stallreq;

    int checks = 0;
    int errors = 0;

    wb_master_bridge_if #(.DW(32), .AW(32)) wb ();

    wb_master_bridge #(.DW(32), .AW(32), .N_STALL(6), .TIMEOUT(4)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_stall    (i_stall),
        .i_flush    (i_flush),
        .i_cpu_ce   (i_cpu_ce),
        .i_cpu_data (i_cpu_data),
        .i_cpu_addr (i_cpu_addr),
        .i_cpu_we   (i_cpu_we),
        .i_cpu_sel  (i_cpu_sel),
        .o_cpu_data (o_cpu_data),
        .o_bus_err  (o_bus_err),
        .o_stallreq (o_stallreq),
        .wb         (wb)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic probe();
        @(negedge i_clk);
    endtask

    task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] sel);
        step();
        i_cpu_ce   = 1'b1;
        i_cpu_we   = we;
        i_cpu_addr = addr;
        i_cpu_data = data;
        i_cpu_sel  = sel;
        probe();
        checks++; if (o_stallreq !== 1'b1) begin errors++; $display("FAIL req_stallreq addr=%0h got %0b exp 1", addr, o_stallreq); end
        checks++; if (wb.o_wishbone_cyc !== 1'b0) begin errors++; $display("FAIL req_cyc addr=%0h got %0b exp 0", addr, wb.o_wishbone_cyc); end
        step();
        // Scramble CPU inputs once latched; the bus must not follow them.
        i_cpu_ce   = 1'b0;
        i_cpu_we   = ~we;
        i_cpu_addr = 32'hBAD0_0000;
        i_cpu_data = 32'hBAD0_BAD0;
        i_cpu_sel  = 4'h0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_stall = '0; i_flush = 0; i_cpu_ce = 0; i_cpu_data = '0;
        i_cpu_addr = '0; i_cpu_we = 0; i_cpu_sel = '0;
        wb.i_wishbone_data = '0; wb.i_wishbone_ack = 0; wb.i_wishbone_err = 0;
        step();
        probe();
        checks++; if (wb.o_wishbone_cyc !== 1'b0) begin errors++; $display("FAIL rst_cyc got %0b exp 0", wb.o_wishbone_cyc); end
        checks++; if (wb.o_wishbone_stb !== 1'b0) begin errors++; $display("FAIL rst_stb got %0b exp 0", wb.o_wishbone_stb); end
        checks++; if (wb.o_wishbone_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", wb.o_wishbone_we); end
        checks++; if (wb.o_wishbone_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %0h exp 0", wb.o_wishbone_addr); end
        checks++; if (wb.o_wishbone_data !== 32'h0) begin errors++; $display("FAIL rst_data got %0h exp 0", wb.o_wishbone_data); end
        checks++; if (wb.o_wishbone_sel !== 4'h0) begin errors++; $display("FAIL rst_sel got %0h exp 0", wb.o_wishbone_sel); end
        checks++; if (o_cpu_data !== 32'h0) begin errors++; $display("FAIL rst_cpu_data got %0h exp 0", o_cpu_data); end
        checks++; if (o_bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err got %0b exp 0", o_bus_err); end
        checks++; if (o_stallreq !== 1'b0) begin errors++; $display("FAIL rst_stallreq got %0b exp 0", o_stallreq); end
        step();
        i_rst = 1'b0;
    endtask

    task automatic test_read();
        request(1'b0, 32'h0000_0100, 32'h0, 4'hF);
        probe();
        checks++; if (wb.o_wishbone_cyc !== 1'b1) begin errors++; $display("FAIL rd_b1_cyc got %0b exp 1", wb.o_wishbone_cyc); end
        checks++; if (wb.o_wishbone_stb !== 1'b1) begin errors++; $display("FAIL rd_b1_stb got %0b exp 1", wb.o_wishbone_stb); end
        checks++; if (wb.o_wishbone_addr !== 32'h100) begin errors++; $display("FAIL rd_b1_addr got %0h exp 100", wb.o_wishbone_addr); end
        checks++; if (wb.o_wishbone_we !== 1'b0) begin errors++; $display("FAIL rd_b1_we got %0b exp 0", wb.o_wishbone_we); end
        checks++; if (o_stallreq !== 1'b1) begin errors++; $display("FAIL rd_b1_stallreq got %0b exp 1", o_stallreq); end
        checks++; if (o_cpu_data !== 32'h0) begin errors++; $display("FAIL rd_b1_cpu_data got %0h exp 0", o_cpu_data); end
        step();
        probe();
        checks++; if (wb.o_wishbone_cyc !== 1'b1) begin errors++; $display("FAIL rd_b2_cyc got %0b exp 1", wb.o_wishbone_cyc); end
        checks++; if (wb.o_wishbone_addr !== 32'h100) begin errors++; $display("FAIL rd_b2_addr got %0h exp 100", wb.o_wishbone_addr); end
        checks++; if (o_stallreq !== 1'b1) begin errors++; $display("FAIL rd_b2_stallreq got %0b exp 1", o_stallreq); end
        step();
        wb.i_wishbone_ack = 1'b1;
        wb.i_wishbone_data = 32'hDEAD_BEEF;
        probe();
        checks++; if (wb.o_wishbone_cyc !== 1'b1) begin errors++; $display("FAIL rd_b3_cyc got %0b exp 1", wb.o_wishbone_cyc); end
        checks++; if (o_cpu_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_b3_cpu_data got %0h exp deadbeef", o_cpu_data); end
        checks++; if (o_stallreq !== 1'b0) begin errors++; $display("FAIL rd_b3_stallreq got %0b exp 0", o_stallreq); end
        checks++; if (o_bus_err !== 1'b0) begin errors++; $display("FAIL rd_b3_bus_err got %0b exp 0", o_bus_err); end
        step();
        wb.i_wishbone_ack = 1'b0;
        wb.i_wishbone_data = 32'h0;
        probe();
        checks++; if (wb.o_wishbone_cyc !== 1'b0) begin errors++; $display("FAIL rd_end_cyc got %0b exp 0", wb.o_wishbone_cyc); end
        checks++; if (wb.o_wishbone_stb !== 1'b0) begin errors++; $display("FAIL rd_end_stb got %0b exp 0", wb.o_wishbone_stb); end
        checks++; if (wb.o_wishbone_addr !== 32'h0) begin errors++; $display("FAIL rd_end_addr got %0h exp 0", wb.o_wishbone_addr); end
        checks++; if (o_cpu_data !== 32'h0) begin errors++; $display("FAIL rd_end_cpu_data got %0h exp 0", o_cpu_data); end
        checks++; if (o_stallreq !== 1'b0) begin errors++; $display("FAIL rd_end_stallreq got %0b exp 0", o_stallreq); end
    endtask

    task automatic test_write_stall();
        request(1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF);
        wb.i_wishbone_ack = 1'b1;
        i_stall = 6'b000100;
        probe();
        checks++; if (wb.o_wishbone_addr !== 32'h200) begin errors++; $display("FAIL wr_addr got %0h exp 200", wb.o_wishbone_addr); end
        checks++; if (wb.o_wishbone_data !== 32'h1234_5678) begin errors++; $display("FAIL wr_data got %0h exp 12345678", wb.o_wishbone_data); end
        checks++; if (wb.o_wishbone_we !== 1'b1) begin errors++; $display("FAIL wr_we got %0b exp 1", wb.o_wishbone_we); end
        checks++; if (wb.o_wishbone_sel !== 4'hF) begin errors++; $display("FAIL wr_sel got %0h exp f", wb.o_wishbone_sel); end
        checks++; if (wb.o_wishbone_cyc !== 1'b1) begin errors++; $display("FAIL wr_cyc got %0b exp 1", wb.o_wishbone_cyc); end
        checks++; if (o_cpu_data !== 32'h0) begin errors++; $display("FAIL wr_cpu_data got %0h exp 0", o_cpu_data); end
        checks++; if (o_stallreq !== 1'b0) begin errors++; $display("FAIL wr_ack_stallreq got %0b exp 0", o_stallreq); end
        step();
        wb.i_wishbone_ack = 1'b0;
        i_cpu_ce = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 32'h0000_0204; i_cpu_sel = 4'hF;
        probe();
        checks++; if (wb.o_wishbone_cyc !== 1'b0) begin errors++; $display("FAIL wr_w1_cyc got %0b exp 0", wb.o_wishbone_cyc); end
        checks++; if (wb.o_wishbone_we !== 1'b0) begin errors++; $display("FAIL wr_w1_we got %0b exp 0", wb.o_wishbone_we); end
        checks++; if (wb.o_wishbone_data !== 32'h0) begin errors++; $display("FAIL wr_w1_data got %0h exp 0", wb.o_wishbone_data); end
        checks++; if (wb.o_wishbone_sel !== 4'h0) begin errors++; $display("FAIL wr_w1_sel got %0h exp 0", wb.o_wishbone_sel); end
        checks++; if (o_stallreq !== 1'b0) begin errors++; $display("FAIL wr_w1_stallreq got %0b exp 0", o_stallreq); end
        checks++; if (o_cpu_data !== 32'h0) begin errors++; $display("FAIL wr_w1_cpu_data got %0h exp 0", o_cpu_data); end
        step();
        i_stall = 6'b0;
        probe();
        checks++; if (o_stallreq !== 1'b0) begin errors++; $display("FAIL wr_w2_stallreq got %0b exp 0", o_stallreq); end
        checks++; if (wb.o_wishbone_cyc !== 1'b0) begin errors++; $display("FAIL wr_w2_cyc got %0b exp 0", wb.o_wishbone_cyc); end
        step();
        probe();
        checks++; if (o_stallreq !== 1'b1) begin errors++; $display("FAIL wr_idle_stallreq got %0b exp 1", o_stallreq); end
        step();
        i_cpu_ce = 1'b0;
        wb.i_wishbone_ack = 1'b1;
        wb.i_wishbone_data = 32'h55AA_1234;
        probe();
        checks++; if (wb.o_wishbone_addr !== 32'h204) begin errors++; $display("FAIL b2b_addr got %0h exp 204", wb.o_wishbone_addr); end
        checks++; if (o_cpu_data !== 32'h55AA_1234) begin errors++; $display("FAIL b2b_cpu_data got %0h exp 55aa1234", o_cpu_data); end
        step();
        wb.i_wishbone_ack = 1'b0;
        wb.i_wishbone_data = 32'h0;
        probe();
        checks++; if (wb.o_wishbone_cyc !== 1'b0) begin errors++; $display("FAIL b2b_end_cyc got %0b exp 0", wb.o_wishbone_cyc); end
    endtask

    task automatic test_timeout();
        request(1'b0, 32'h0000_0300, 32'h0, 4'hF);
        for (int i = 1; i <= 4; i++) begin
            probe();
            checks++; if (wb.o_wishbone_cyc !== 1'b1) begin errors++; $display("FAIL tmo_cyc cycle=%0d got %0b exp 1", i, wb.o_wishbone_cyc); end
            checks++; if (o_bus_err !== (i == 4)) begin errors++; $display("FAIL tmo_bus_err cycle=%0d got %0b exp %0b", i, o_bus_err, (i == 4)); end
            checks++; if (o_stallreq !== (i != 4)) begin errors++; $display("FAIL tmo_stallreq cycle=%0d got %0b exp %0b", i, o_stallreq, (i != 4)); end
            step();
        end
        probe();
        checks++; if (wb.o_wishbone_cyc !== 1'b0) begin errors++; $display("FAIL tmo_end_cyc got %0b exp 0", wb.o_wishbone_cyc); end
        checks++; if (o_bus_err !== 1'b0) begin errors++; $display("FAIL tmo_end_bus_err got %0b exp 0", o_bus_err); end
    endtask

    task automatic test_ack_err();
        request(1'b0, 32'h0000_0400, 32'h0, 4'hF);
        wb.i_wishbone_ack = 1'b1;
        wb.i_wishbone_err = 1'b1;
        wb.i_wishbone_data = 32'hFFFF_FFFF;
        i_stall = 6'b000001;
        probe();
        checks++; if (o_bus_err !== 1'b1) begin errors++; $display("FAIL ae_bus_err got %0b exp 1", o_bus_err); end
        checks++; if (o_cpu_data !== 32'h0) begin errors++; $display("FAIL ae_cpu_data got %0h exp 0", o_cpu_data); end
        checks++; if (o_stallreq !== 1'b0) begin errors++; $display("FAIL ae_stallreq got %0b exp 0", o_stallreq); end
        step();
        wb.i_wishbone_ack = 1'b0;
        wb.i_wishbone_err = 1'b0;
        wb.i_wishbone_data = 32'h0;
        i_stall = 6'b0;
        probe();
        checks++; if (o_bus_err !== 1'b1) begin errors++; $display("FAIL ae_wait_bus_err got %0b exp 1", o_bus_err); end
        checks++; if (o_cpu_data !== 32'h0) begin errors++; $display("FAIL ae_wait_cpu_data got %0h exp 0", o_cpu_data); end
        checks++; if (wb.o_wishbone_cyc !== 1'b0) begin errors++; $display("FAIL ae_wait_cyc got %0b exp 0", wb.o_wishbone_cyc); end
        step();
        probe();
        checks++; if (o_bus_err !== 1'b0) begin errors++; $display("FAIL ae_idle_bus_err got %0b exp 0", o_bus_err); end
    endtask

    task automatic test_flush();
        request(1'b0, 32'h0000_0500, 32'h0, 4'hF);
        probe();
        checks++; if (wb.o_wishbone_cyc !== 1'b1) begin errors++; $display("FAIL fl_b1_cyc got %0b exp 1", wb.o_wishbone_cyc); end
        step();
        i_flush = 1'b1;
        wb.i_wishbone_ack = 1'b1;
        wb.i_wishbone_data = 32'h1111_2222;
        probe();
        checks++; if (o_cpu_data !== 32'h0) begin errors++; $display("FAIL fl_cpu_data got %0h exp 0", o_cpu_data); end
        checks++; if (o_bus_err !== 1'b0) begin errors++; $display("FAIL fl_bus_err got %0b exp 0", o_bus_err); end
        step();
        i_flush = 1'b0;
        wb.i_wishbone_ack = 1'b0;
        wb.i_wishbone_data = 32'h0;
        probe();
        checks++; if (wb.o_wishbone_cyc !== 1'b0) begin errors++; $display("FAIL fl_end_cyc got %0b exp 0", wb.o_wishbone_cyc); end
        checks++; if (wb.o_wishbone_stb !== 1'b0) begin errors++; $display("FAIL fl_end_stb got %0b exp 0", wb.o_wishbone_stb); end
        checks++; if (o_cpu_data !== 32'h0) begin errors++; $display("FAIL fl_end_cpu_data got %0h exp 0", o_cpu_data); end
        step();
        i_cpu_ce = 1'b1; i_flush = 1'b1; i_cpu_addr = 32'h0000_0508;
        probe();
        checks++; if (o_stallreq !== 1'b0) begin errors++; $display("FAIL fl_idle_stallreq got %0b exp 0", o_stallreq); end
        step();
        i_cpu_ce = 1'b0; i_flush = 1'b0;
        probe();
        checks++; if (wb.o_wishbone_cyc !== 1'b0) begin errors++; $display("FAIL fl_idle_cyc got %0b exp 0", wb.o_wishbone_cyc); end
    endtask

    task automatic test_reset_busy();
        request(1'b0, 32'h0000_0600, 32'h0, 4'hF);
        probe();
        checks++; if (wb.o_wishbone_cyc !== 1'b1) begin errors++; $display("FAIL rb_b1_cyc got %0b exp 1", wb.o_wishbone_cyc); end
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        wb.i_wishbone_ack = 1'b1;
        wb.i_wishbone_data = 32'h0000_0077;
        probe();
        checks++; if (wb.o_wishbone_cyc !== 1'b0) begin errors++; $display("FAIL rb_cyc got %0b exp 0", wb.o_wishbone_cyc); end
        checks++; if (wb.o_wishbone_stb !== 1'b0) begin errors++; $display("FAIL rb_stb got %0b exp 0", wb.o_wishbone_stb); end
        checks++; if (wb.o_wishbone_addr !== 32'h0) begin errors++; $display("FAIL rb_addr got %0h exp 0", wb.o_wishbone_addr); end
        checks++; if (o_cpu_data !== 32'h0) begin errors++; $display("FAIL rb_cpu_data got %0h exp 0", o_cpu_data); end
        checks++; if (o_bus_err !== 1'b0) begin errors++; $display("FAIL rb_bus_err got %0b exp 0", o_bus_err); end
        checks++; if (o_stallreq !== 1'b0) begin errors++; $display("FAIL rb_stallreq got %0b exp 0", o_stallreq); end
        step();
        wb.i_wishbone_ack = 1'b0;
        wb.i_wishbone_data = 32'h0;
        probe();
        checks++; if (wb.o_wishbone_cyc !== 1'b0) begin errors++; $display("FAIL rb_after_cyc got %0b exp 0", wb.o_wishbone_cyc); end
    endtask

    task automatic test_read_wait();
        request(1'b0, 32'h0000_0700, 32'h0, 4'hF);
        wb.i_wishbone_ack = 1'b1;
        wb.i_wishbone_data = 32'hA5A5_5A5A;
        i_stall = 6'b100000;
        probe();
        checks++; if (o_cpu_data !== 32'hA5A5_5A5A) begin errors++; $display("FAIL rw_ack_cpu_data got %0h exp a5a55a5a", o_cpu_data); end
        step();
        wb.i_wishbone_data = 32'h0;
        probe();
        checks++; if (o_cpu_data !== 32'hA5A5_5A5A) begin errors++; $display("FAIL rw_w1_cpu_data got %0h exp a5a55a5a", o_cpu_data); end
        checks++; if (wb.o_wishbone_cyc !== 1'b0) begin errors++; $display("FAIL rw_w1_cyc got %0b exp 0", wb.o_wishbone_cyc); end
        checks++; if (o_bus_err !== 1'b0) begin errors++; $display("FAIL rw_w1_bus_err got %0b exp 0", o_bus_err); end
        step();
        wb.i_wishbone_ack = 1'b0;
        i_stall = 6'b0;
        probe();
        checks++; if (o_cpu_data !== 32'hA5A5_5A5A) begin errors++; $display("FAIL rw_w2_cpu_data got %0h exp a5a55a5a", o_cpu_data); end
        step();
        probe();
        checks++; if (o_cpu_data !== 32'h0) begin errors++; $display("FAIL rw_idle_cpu_data got %0h exp 0", o_cpu_data); end
        checks++; if (wb.o_wishbone_cyc !== 1'b0) begin errors++; $display("FAIL rw_idle_cyc got %0b exp 0", wb.o_wishbone_cyc); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_stall();
        test_timeout();
        test_ack_err();
        test_flush();
        test_reset_busy();
        test_read_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width; legal values are 32 and 64.
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have parameter N_STALL, default 6, meaning pipeline stall vector width.
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of BUSY cycles before forced termination; 0 disables the timeout.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL have the following ports:
- i_clk  in  1  clock; all logic samples on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_stall  in  N_STALL  pipeline stall vector.
- i_flush  in  1  pipeline flush.
- i_cpu_ce  in  1  CPU request valid.
- i_cpu_data  in  DW  CPU write data.
- i_cpu_addr  in  AW  CPU address.
- i_cpu_we  in  1  CPU write enable; 1 = write.
- i_cpu_sel  in  DW/8  CPU byte selects.
- o_cpu_data  out  DW  read data returned to the CPU.
- o_bus_err  out  1  the current access terminated by error or timeout.
- o_stallreq  out  1  stall request to the pipeline.
- o_wishbone_addr  out  AW  bus address.
- o_wishbone_data  out  DW  bus write data.
- o_wishbone_we  out  1  bus write enable.
- o_wishbone_sel  out  DW/8  bus byte selects.
- o_wishbone_stb  out  1  bus strobe.
- o_wishbone_cyc  out  1  bus cycle.
- i_wishbone_data  in  DW  bus read data.
- i_wishbone_ack  in  1  bus acknowledge.
- i_wishbone_err  in  1  bus error termination.

Function
REQ-007 SHALL implement the states IDLE, BUSY and WAIT.
REQ-008 SHALL, in IDLE with i_cpu_ce=1 and i_flush=0, latch addr, data, we and sel, enter BUSY, and drive cyc=stb=1 with the latched fields from the next cycle.
REQ-009 SHALL drive all o_wishbone_* outputs from registers, holding them stable for the whole of BUSY.
REQ-010 SHALL ignore changes on the i_cpu_* inputs while in BUSY or WAIT.
REQ-011 SHALL terminate the access in BUSY on i_wishbone_ack, i_wishbone_err, or timeout.
REQ-012 SHALL deassert cyc, stb and we and zero addr, data and sel on the cycle after termination.
REQ-013 SHALL move from termination to WAIT if i_stall!=0, otherwise to IDLE.
REQ-014 SHALL move from BUSY to IDLE on i_flush=1, with cyc=stb=0 on the next cycle, no data returned and o_bus_err=0.
REQ-015 SHALL, in WAIT, return to IDLE on the first cycle with i_stall==0.
REQ-016 SHALL start the timeout counter at 0 on BUSY entry and increment it once per BUSY cycle.
REQ-017 SHALL treat counter==TIMEOUT-1 with no ack and no err as timeout, terminating with error.
REQ-018 SHALL drive o_stallreq=1 combinationally in IDLE when i_cpu_ce=1 and i_flush=0.
REQ-019 SHALL drive o_stallreq=1 in BUSY on every cycle without termination.
REQ-020 SHALL drive o_stallreq=0 on the termination cycle and in all other cases.
REQ-021 SHALL, on a read terminated by ack, drive o_cpu_data=i_wishbone_data combinationally on the ack cycle and capture it in a register.
REQ-022 SHALL, in WAIT, drive o_cpu_data from the captured register.
REQ-023 SHALL drive o_cpu_data=0 for writes, error or timeout terminations, and in IDLE.
REQ-024 SHALL assert o_bus_err on an err or timeout termination cycle and hold it throughout the following WAIT; it SHALL be 0 otherwise.
REQ-025 SHALL give err priority over ack when both are asserted together: o_bus_err=1, o_cpu_data=0.
REQ-026 SHALL give flush priority over ack, err and timeout in the same BUSY cycle.
REQ-027 SHALL ignore ack and err received in IDLE or WAIT.
REQ-028 SHALL, in IDLE with i_cpu_ce=1 and i_flush=1, stay in IDLE with o_stallreq=0 and issue no bus cycle.
REQ-029 SHALL map an illegal state encoding to IDLE on the next cycle.

Reset
REQ-030 SHALL, on i_rst=1 at a clock edge, set the state to IDLE and clear the counter, the latched request and the captured data.
REQ-031 SHALL, after reset, hold all o_wishbone_* at 0 and o_cpu_data, o_bus_err and o_stallreq at 0.
REQ-032 SHALL, on reset during BUSY, drop cyc and stb on the next cycle, and ignore any later ack.

Verification
REQ-033 SHALL verify a read: ce=1, we=0, addr=0x100, ack on the 3rd BUSY cycle with data 0xDEADBEEF and stall=0 -> cyc high for 3 cycles, o_cpu_data=0xDEADBEEF on the ack cycle, stallreq 1,1,1,0, then IDLE.
REQ-034 SHALL verify a write then stall: we=1, sel=0xF, data=0x12345678, ack with stall=6'b000100 held for 2 cycles -> bus fields match, o_cpu_data=0, WAIT for 2 cycles, then IDLE.
REQ-035 SHALL verify a timeout: TIMEOUT=4, no ack -> cyc high for exactly 4 cycles, o_bus_err=1 on the 4th cycle, cyc=0 on the next.
REQ-036 SHALL verify ack and err together: ack=err=1 on a read -> o_bus_err=1 and o_cpu_data=0.
REQ-037 SHALL verify flush mid-access: flush on the 2nd BUSY cycle with ack in the same cycle -> IDLE, cyc=0 next cycle, o_cpu_data=0, o_bus_err=0.
REQ-038 SHALL verify reset in BUSY: i_rst=1 for 1 cycle during BUSY -> all outputs 0 on the next cycle, and a subsequent ack is ignored.
